// File: rtl/seq_det_pkg.sv
// Shared definitions for the 101 sequence detector and its match monitor.
package seq_det_pkg;

    // Monitor FSM encoding
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mon_state_t;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;

    // 101 detector state encoding (S0: nothing, S1: seen 1, S2: seen 10)
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } det_state_t;

endpackage

// File: rtl/seq_match_monitor_if.sv
// Window report channel: valid/ready handshake carrying count, saturation and drop info.
interface seq_match_monitor_if
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_count;
    logic             rpt_sat;
    logic             rpt_drop;

    modport master (
        output rpt_valid,
        output rpt_count,
        output rpt_sat,
        output rpt_drop,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_count,
        input  rpt_sat,
        input  rpt_drop,
        output rpt_ready
    );
endinterface

// File: rtl/seq_match_monitor_sat_counter.sv
// Saturating event counter with sticky saturation flag; clear has priority over increment.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    // Count up on inc, hold at all-ones and flag the would-be wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc) begin
            if (cnt == '1) begin
                sat <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_match_monitor.sv
// Counts match pulses over programmable windows, reports each window count over a
// valid/ready channel and raises a sticky alarm when a count reaches the threshold.
//
// state | meaning
// IDLE  | monitor stopped, waiting for en
// RUN   | window in progress; win_cnt = remaining cycles after this one
module seq_match_monitor
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                match,
    input  logic [WIN_W-1:0]    window_len,
    input  logic [CNT_W-1:0]    threshold,
    seq_match_monitor_if.master rpt,
    output logic                alarm,
    input  logic                alarm_clr,
    output logic                busy
);

    mon_state_t       state;
    mon_state_t       state_next;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_start;
    logic             win_last;
    logic             win_load;
    logic             win_dec;
    logic             acc_inc;
    logic             acc_clr;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_sat;
    logic [CNT_W-1:0] final_cnt;
    logic             final_sat;
    logic             rpt_load;
    logic             alarm_set;
    logic             rpt_valid_q;
    logic [CNT_W-1:0] rpt_count_q;
    logic             rpt_sat_q;
    logic             rpt_drop_q;

    // A zero window length behaves as a one-cycle window
    assign win_start = (window_len == '0) ? '0 : window_len - 1'b1;
    assign win_last  = (win_cnt == '0);

    // The reported count must include the last cycle's match, which the
    // accumulator has not absorbed yet, so fold it in here.
    assign final_cnt = (match && (acc_cnt != '1)) ? acc_cnt + 1'b1 : acc_cnt;
    assign final_sat = acc_sat | (match & (acc_cnt == '1));
    assign alarm_set = rpt_load && (threshold != '0) && (final_cnt >= threshold);

    sat_counter #(.CNT_W(CNT_W)) u_acc (
        .clk (clk),
        .rst (rst),
        .inc (acc_inc),
        .clr (acc_clr),
        .cnt (acc_cnt),
        .sat (acc_sat)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start on en, leave RUN on abort or on a window end without en
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (en) state_next = RUN;
            RUN:  if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs and datapath controls
    always_comb begin
        busy     = 1'b0;
        win_load = 1'b0;
        win_dec  = 1'b0;
        acc_inc  = 1'b0;
        acc_clr  = 1'b0;
        rpt_load = 1'b0;
        case (state)
            IDLE: begin
                win_load = en;
                acc_clr  = en;
            end
            RUN: begin
                busy     = 1'b1;
                acc_inc  = match;
                rpt_load = win_last;
                win_dec  = ~win_last;
                win_load = win_last & en;
                acc_clr  = win_last & en;
            end
            default: ;
        endcase
    end

    // Window down-counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt <= '0;
        end else if (win_load) begin
            win_cnt <= win_start;
        end else if (win_dec) begin
            win_cnt <= win_cnt - 1'b1;
        end
    end

    // Report register; a load over an unaccepted report marks it as dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_valid_q <= 1'b0;
            rpt_count_q <= '0;
            rpt_sat_q   <= 1'b0;
            rpt_drop_q  <= 1'b0;
        end else if (rpt_load) begin
            rpt_valid_q <= 1'b1;
            rpt_count_q <= final_cnt;
            rpt_sat_q   <= final_sat;
            rpt_drop_q  <= rpt_valid_q & ~rpt.rpt_ready;
        end else if (rpt_valid_q && rpt.rpt_ready) begin
            rpt_valid_q <= 1'b0;
            rpt_drop_q  <= 1'b0;
        end
    end

    assign rpt.rpt_valid = rpt_valid_q;
    assign rpt.rpt_count = rpt_count_q;
    assign rpt.rpt_sat   = rpt_sat_q;
    assign rpt.rpt_drop  = rpt_drop_q;

    // Sticky alarm; a new crossing beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm <= 1'b0;
        end else if (alarm_set) begin
            alarm <= 1'b1;
        end else if (alarm_clr) begin
            alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Bench for seq_match_monitor: an 8-bit and a 4-bit counter instance share the same
// stimulus and are compared every cycle against a window-level reference model.
module tb_seq_match_monitor;

    logic        clk;
    logic        rst;
    logic        en;
    logic        match;
    logic [15:0] wl;
    logic [7:0]  thr;
    logic        ready;
    logic        aclr;
    logic        alarm8, alarm4, busy8, busy4;

    int n_chk = 0;
    int n_fail = 0;

    seq_match_monitor_if #(.CNT_W(8)) if8 ();
    seq_match_monitor_if #(.CNT_W(4)) if4 ();

    assign if8.rpt_ready = ready;
    assign if4.rpt_ready = ready;

    seq_match_monitor #(.CNT_W(8), .WIN_W(16)) dut8 (
        .clk(clk), .rst(rst), .en(en), .match(match), .window_len(wl),
        .threshold(thr), .rpt(if8.master), .alarm(alarm8), .alarm_clr(aclr), .busy(busy8)
    );

    seq_match_monitor #(.CNT_W(4), .WIN_W(16)) dut4 (
        .clk(clk), .rst(rst), .en(en), .match(match), .window_len(wl),
        .threshold(thr[3:0]), .rpt(if4.master), .alarm(alarm4), .alarm_clr(aclr), .busy(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] o_valid [2];
    logic [31:0] o_count [2];
    logic [31:0] o_sat   [2];
    logic [31:0] o_drop  [2];
    logic [31:0] o_alarm [2];
    logic [31:0] o_busy  [2];

    always_comb begin
        o_valid[0] = {31'd0, if8.rpt_valid};
        o_count[0] = {24'd0, if8.rpt_count};
        o_sat[0]   = {31'd0, if8.rpt_sat};
        o_drop[0]  = {31'd0, if8.rpt_drop};
        o_alarm[0] = {31'd0, alarm8};
        o_busy[0]  = {31'd0, busy8};
        o_valid[1] = {31'd0, if4.rpt_valid};
        o_count[1] = {28'd0, if4.rpt_count};
        o_sat[1]   = {31'd0, if4.rpt_sat};
        o_drop[1]  = {31'd0, if4.rpt_drop};
        o_alarm[1] = {31'd0, alarm4};
        o_busy[1]  = {31'd0, busy4};
    end

    // Reference model: window position tracked as cycles left, true unbounded match count
    int m_maxc  [2] = '{255, 15};
    bit m_run   [2];
    int m_left  [2];
    int m_cnt   [2];
    bit m_valid [2];
    int m_count [2];
    bit m_sat   [2];
    bit m_drop  [2];
    bit m_alarm [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_left[d] = 0; m_cnt[d] = 0;
            m_valid[d] = 0; m_count[d] = 0; m_sat[d] = 0; m_drop[d] = 0; m_alarm[d] = 0;
        end
    endtask

    task automatic model_edge();
        int len;
        len = (wl == 0) ? 1 : int'(wl);
        for (int d = 0; d < 2; d++) begin
            bit rep, acc, fsat;
            int fin;
            rep = 0; fin = 0; fsat = 0;
            acc = m_valid[d] && ready;
            if (!m_run[d]) begin
                if (en) begin
                    m_run[d] = 1; m_left[d] = len; m_cnt[d] = 0;
                end
            end else begin
                m_cnt[d] += int'(match);
                m_left[d]--;
                if (m_left[d] == 0) begin
                    rep  = 1;
                    fin  = (m_cnt[d] > m_maxc[d]) ? m_maxc[d] : m_cnt[d];
                    fsat = (m_cnt[d] > m_maxc[d]);
                    if (en) begin
                        m_left[d] = len; m_cnt[d] = 0;
                    end else begin
                        m_run[d] = 0;
                    end
                end else if (!en) begin
                    m_run[d] = 0;
                end
            end
            if (rep) begin
                m_drop[d]  = m_valid[d] && !ready;
                m_valid[d] = 1; m_count[d] = fin; m_sat[d] = fsat;
            end else if (acc) begin
                m_valid[d] = 0; m_drop[d] = 0;
            end
            m_alarm[d] = (rep && thr != 0 && fin >= int'(thr)) || (m_alarm[d] && !aclr);
        end
    endtask

    // One clock: model follows the edge, then all outputs are compared at the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("valid%0d", d), o_valid[d], 32'(m_valid[d]));
            chk($sformatf("count%0d", d), o_count[d], 32'(m_count[d]));
            chk($sformatf("sat%0d", d),   o_sat[d],   32'(m_sat[d]));
            chk($sformatf("drop%0d", d),  o_drop[d],  32'(m_drop[d]));
            chk($sformatf("alarm%0d", d), o_alarm[d], 32'(m_alarm[d]));
            chk($sformatf("busy%0d", d),  o_busy[d],  32'(m_run[d]));
        end
    endtask

    task automatic cyc(input bit e, input bit m);
        en = e; match = m;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_valid"}, o_valid[d], 0);
            chk({tag, "_count"}, o_count[d], 0);
            chk({tag, "_sat"},   o_sat[d],   0);
            chk({tag, "_drop"},  o_drop[d],  0);
            chk({tag, "_alarm"}, o_alarm[d], 0);
            chk({tag, "_busy"},  o_busy[d],  0);
        end
    endtask

    initial begin
        bit [1:0] hist;
        bit       x;

        rst = 1'b0; en = 0; match = 0; wl = 16'd0; thr = 8'd0; ready = 1'b1; aclr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // Window of 8 with matches at cycles 2, 5, 8; next window follows with no gap
        wl = 16'd8;
        cyc(1, 0);
        for (int i = 1; i <= 8; i++) cyc(1, (i == 2 || i == 5 || i == 8));
        chk("t1_valid", o_valid[0], 1);
        chk("t1_count", o_count[0], 3);
        chk("t1_sat",   o_sat[0],   0);
        chk("t1_drop",  o_drop[0],  0);
        chk("t1_busy",  o_busy[0],  1);
        cyc(0, 0);
        cyc(0, 0);

        // x = 1,0,1,0,1 through a 101 detector model into a window of 10
        wl = 16'd10;
        hist = 2'b00;
        cyc(1, 0);
        for (int i = 1; i <= 10; i++) begin
            x = (i <= 5) && (i % 2 == 1);
            cyc((i != 10), (hist == 2'b10) && x);
            hist = {hist[0], x};
        end
        chk("t2_count", o_count[0], 2);
        chk("t2_valid", o_valid[0], 1);
        cyc(0, 0);

        // 20 matches in a window of 20: the 4-bit instance saturates
        wl = 16'd20;
        cyc(1, 0);
        for (int i = 1; i <= 20; i++) cyc((i != 20), 1);
        chk("t3_count4", o_count[1], 15);
        chk("t3_sat4",   o_sat[1],   1);
        chk("t3_count8", o_count[0], 20);
        chk("t3_sat8",   o_sat[0],   0);
        cyc(0, 0);

        // Back-to-back reports with ready low: second overwrites and is flagged
        ready = 1'b0; wl = 16'd4;
        cyc(1, 0);
        for (int i = 1; i <= 4; i++) cyc(1, (i == 1));
        chk("t4_count_a", o_count[0], 1);
        chk("t4_drop_a",  o_drop[0],  0);
        for (int i = 1; i <= 4; i++) cyc((i != 4), (i != 4));
        chk("t4_count_b", o_count[0], 3);
        chk("t4_drop_b",  o_drop[0],  1);
        chk("t4_valid_b", o_valid[0], 1);
        ready = 1'b1;
        cyc(0, 0);
        chk("t4_valid_c", o_valid[0], 0);
        chk("t4_drop_c",  o_drop[0],  0);

        // Alarm: crossing, clear alone, clear together with a new crossing
        thr = 8'd2;
        cyc(1, 0);
        for (int i = 1; i <= 4; i++) cyc(1, (i <= 2));
        chk("t5_alarm_set", o_alarm[0], 1);
        aclr = 1'b1;
        cyc(1, 0);
        aclr = 1'b0;
        chk("t5_alarm_clr", o_alarm[0], 0);
        for (int i = 2; i <= 4; i++) cyc(1, 0);
        for (int i = 1; i <= 4; i++) begin
            aclr = (i == 4);
            cyc((i != 4), (i <= 2));
        end
        aclr = 1'b0;
        chk("t5_alarm_win", o_alarm[0], 1);
        thr = 8'd0;

        // Abort at cycle 3 of 8 after two matches
        wl = 16'd8;
        cyc(1, 0);
        cyc(1, 1);
        cyc(1, 1);
        cyc(0, 0);
        chk("t6_busy",  o_busy[0],  0);
        chk("t6_valid", o_valid[0], 0);
        cyc(0, 0);
        chk("t6_valid2", o_valid[0], 0);

        // Asynchronous reset mid-window with a pending report and alarm set
        ready = 1'b0; thr = 8'd1; wl = 16'd4;
        cyc(1, 0);
        for (int i = 1; i <= 4; i++) cyc(1, (i == 1));
        chk("t7_pre_valid", o_valid[0], 1);
        chk("t7_pre_alarm", o_alarm[0], 1);
        cyc(1, 1);
        cyc(1, 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk_all_zero("t7_rst");
        @(negedge clk);
        rst = 1'b1; en = 0; match = 0; thr = 8'd0; ready = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom % 16) != 0;
            match = ($urandom % 3) == 0;
            wl    = 16'($urandom % 7);
            thr   = 8'($urandom % 6);
            ready = ($urandom % 4) != 0;
            aclr  = ($urandom % 8) == 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
